// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin sharing of one async-FIFO read port
// among NREQ read-domain consumers, with burst cap and empty timeout.
module fifo_rd_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             rclk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             rd_en_o,
  input  logic             empty_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             error_i,
  output logic [NREQ-1:0]  vld_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);
  localparam logic [IW:0]   LP_N     = (IW + 1)'(NREQ);
  localparam logic [BW-1:0] LP_BLAST = BW'(BURST - 1);
  localparam logic [7:0]    LP_TLAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [NREQ-1:0]   r_vld;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [BW-1:0]     r_bcnt;
  logic [BW-1:0]     w_bcnt_nxt;
  logic [7:0]        r_tcnt;
  logic [7:0]        w_tcnt_nxt;
  logic              r_err;
  logic              r_rd_q;

  logic [2*NREQ-1:0] w_req2;
  logic [IW-1:0]     w_off;
  logic              w_found;
  logic [IW:0]       w_sum;
  logic [IW:0]       w_wrap;
  logic [IW-1:0]     w_win;
  logic [IW:0]       w_inc;
  logic              w_granted;
  logic              w_req_g;
  logic              w_rd_en;
  logic              w_to_inc;
  logic              w_last_rd;
  logic              w_tmo;

  assign w_granted = (r_state == S_GRANT);
  assign w_req_g   = |(req_i & r_gnt);
  assign w_rd_en   = w_granted & w_req_g & ~empty_i;
  assign w_to_inc  = w_granted & w_req_g & empty_i;
  assign w_last_rd = w_rd_en & (r_bcnt == LP_BLAST);
  assign w_tmo     = w_to_inc & (r_tcnt == LP_TLAST);

  // Rotate requests so bit 0 is the pointer position
  assign w_req2 = {req_i, req_i} >> r_ptr;

  // First set request at or above the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_req2[i]) begin
        w_found = 1'b1;
        w_off   = IW'(i);
      end
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_wrap = w_sum - LP_N;
  assign w_win  = (w_sum >= LP_N) ? w_wrap[IW-1:0] : w_sum[IW-1:0];
  assign w_inc  = {1'b0, w_win} + (IW + 1)'(1);

  // Next-state, grant and counter updates
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_bcnt_nxt  = r_bcnt;
    w_tcnt_nxt  = r_tcnt;
    unique case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_ptr_nxt   = (w_inc == LP_N) ? '0 : w_inc[IW-1:0];
          w_bcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (w_rd_en) begin
          w_bcnt_nxt = r_bcnt + BW'(1);
          w_tcnt_nxt = '0;
        end else if (w_to_inc) begin
          w_tcnt_nxt = r_tcnt + 8'd1;
        end
        if (w_last_rd | ~w_req_g | w_tmo) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State, grant, counters, data-valid tag and sticky error
  always_ff @(posedge rclk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
      r_tcnt  <= '0;
      r_vld   <= '0;
      r_rd_q  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_vld   <= w_rd_en ? r_gnt : '0;
      r_rd_q  <= w_rd_en;
      r_err   <= r_err | (error_i & (w_granted | r_rd_q));
    end
  end

  assign gnt_o   = r_gnt;
  assign rd_en_o = w_rd_en;
  assign vld_o   = r_vld;
  assign rdata_o = rdata_i;
  assign busy_o  = w_granted;
  assign err_o   = r_err;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: FIFO model plus scoreboard of tagged read data,
// with grant/read logs checked against round-robin burst behaviour.
module tb_fifo_rd_arbiter;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  vld;
  logic             rd_en;
  logic             empty;
  logic             err_in;
  logic             busy;
  logic             err;
  logic [WIDTH-1:0] rdata_in;
  logic [WIDTH-1:0] rdata_out;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk_i (clk),
    .rst_i  (rst_n),
    .req_i  (req),
    .gnt_o  (gnt),
    .rd_en_o(rd_en),
    .empty_i(empty),
    .rdata_i(rdata_in),
    .error_i(err_in),
    .vld_o  (vld),
    .rdata_o(rdata_out),
    .busy_o (busy),
    .err_o  (err)
  );

  typedef struct packed {
    logic [NREQ-1:0]  v;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             e_cur;
  logic [WIDTH-1:0] fifo_q[$];
  logic             hold_empty = 1'b0;
  logic             pop_req = 1'b0;
  logic [NREQ-1:0]  prev_gnt = '0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_total = 0;
  int g_val[$];
  int g_cyc[$];
  int g_rds[$];
  int g_len[$];
  int rd_cyc[$];

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
               tag, act, exp, cyc);
    end
  endtask

  task automatic upd_empty();
    empty = hold_empty || (fifo_q.size() == 0);
  endtask

  task automatic clr_logs();
    g_val.delete();
    g_cyc.delete();
    g_rds.delete();
    g_len.delete();
    rd_cyc.delete();
    rd_total = 0;
  endtask

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(WIDTH'(base + i));
    upd_empty();
  endtask

  // FIFO model: pop the word read at the previous edge
  always begin
    @(posedge clk);
    #1;
    if (pop_req && fifo_q.size() > 0) rdata_in = fifo_q.pop_front();
    pop_req = 1'b0;
    upd_empty();
  end

  // Monitor: scoreboard compare, per-cycle rules, grant/read logs
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb_q.delete();
      pop_req  = 1'b0;
      prev_gnt = '0;
    end else begin
      if (sb_q.size() > 0) begin
        e_cur = sb_q.pop_front();
        chk("vld", 32'(vld), 32'(e_cur.v));
        chk("rdata", 32'(rdata_out), 32'(e_cur.d));
      end else begin
        chk("vld_idle", 32'(vld), 32'(0));
      end
      chk("busy", 32'(busy), 32'(gnt != '0));
      chk("gnt_1hot", 32'($onehot0(gnt)), 32'(1));
      chk("rd_en", 32'(rd_en), 32'(((gnt & req) != '0) && !empty));
      if (gnt != '0 && prev_gnt == '0) begin
        g_val.push_back(int'(gnt));
        g_cyc.push_back(cyc);
        g_rds.push_back(0);
        g_len.push_back(0);
      end
      if (gnt != '0 && g_len.size() > 0)
        g_len[g_len.size()-1] = g_len[g_len.size()-1] + 1;
      if (rd_en) begin
        sb_q.push_back(exp_t'({gnt, fifo_q[0]}));
        pop_req = 1'b1;
        rd_total++;
        rd_cyc.push_back(cyc);
        if (g_rds.size() > 0)
          g_rds[g_rds.size()-1] = g_rds[g_rds.size()-1] + 1;
      end
      prev_gnt = gnt;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    err_in = 1'b0;
    hold_empty = 1'b0;
    fifo_q.delete();
    upd_empty();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clr_logs();
  endtask

  task automatic wait_rd(input int n, input int budget, input string tag);
    int k = 0;
    while (rd_total < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk(tag, 32'(rd_total), 32'(n));
  endtask

  task automatic wait_grants(input int n, input int budget,
                             input string tag);
    int k = 0;
    while (g_val.size() < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk(tag, 32'(g_val.size() >= n), 32'(1));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (busy && k < budget);
    chk(tag, 32'(busy), 32'(0));
  endtask

  task automatic chk_grant(input string tag, input int i,
                           input int val, input int rds);
    if (i < g_val.size()) begin
      chk({tag, "_gnt"}, 32'(g_val[i]), 32'(val));
      chk({tag, "_rds"}, 32'(g_rds[i]), 32'(rds));
    end else begin
      chk({tag, "_cnt"}, 32'(g_val.size()), 32'(i + 1));
    end
  endtask

  task automatic chk_gap(input string tag, input int i, input int gap);
    if (i < g_cyc.size())
      chk(tag, 32'(g_cyc[i] - g_cyc[i-1]), 32'(gap));
    else
      chk({tag, "_cnt"}, 32'(g_cyc.size()), 32'(i + 1));
  endtask

  task automatic chk_rdgap(input string tag, input int i, input int gap);
    if (i < rd_cyc.size())
      chk(tag, 32'(rd_cyc[i] - rd_cyc[i-1]), 32'(gap));
    else
      chk({tag, "_cnt"}, 32'(rd_cyc.size()), 32'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    err_in = 1'b0;
    rdata_in = '0;
    empty = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_vld", 32'(vld), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_rd_en", 32'(rd_en), 32'(0));

    // Single requester 1, ten words
    @(posedge clk);
    #2;
    clr_logs();
    push_words(10, 8'h10);
    req = 4'b0010;
    wait_rd(10, 100, "t1_reads");
    req = '0;
    wait_idle(20, "t1_idle");
    chk("t1_ngrants", 32'(g_val.size()), 32'(3));
    chk_grant("t1_g0", 0, 2, 4);
    chk_grant("t1_g1", 1, 2, 4);
    chk_grant("t1_g2", 2, 2, 2);
    chk_gap("t1_gap1", 1, BURST + 1);
    chk_gap("t1_gap2", 2, BURST + 1);
    if (rd_cyc.size() > 0 && g_cyc.size() > 0)
      chk("t1_first_rd", 32'(rd_cyc[0]), 32'(g_cyc[0]));
    chk_rdgap("t1_bubble", 4, 2);

    // All four request, FIFO always non-empty
    do_reset();
    push_words(40, 8'h40);
    req = 4'b1111;
    wait_grants(5, 60, "t2_grants");
    req = '0;
    wait_idle(20, "t2_idle");
    for (int i = 0; i < 4; i++) chk_grant("t2", i, 1 << i, BURST);
    chk_grant("t2_wrap", 4, 1, g_rds.size() > 4 ? g_rds[4] : 0);
    for (int i = 1; i < 5; i++) chk_gap("t2_gap", i, BURST + 1);

    // Grant with FIFO empty: timeout release
    do_reset();
    req = 4'b0001;
    wait_grants(1, 10, "t3_grant");
    wait_idle(20, "t3_idle");
    req = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_grant("t3", 0, 1, 0);
    if (g_len.size() > 0)
      chk("t3_len", 32'(g_len[0]), 32'(TIMEOUT));
    chk("t3_rd_total", 32'(rd_total), 32'(0));
    chk("t3_busy", 32'(busy), 32'(0));

    // FIFO empty for 3 cycles mid-burst
    do_reset();
    push_words(10, 8'h80);
    req = 4'b0001;
    wait_rd(2, 20, "t4_rd2");
    hold_empty = 1'b1;
    upd_empty();
    repeat (3) @(posedge clk);
    #2;
    hold_empty = 1'b0;
    upd_empty();
    wait_rd(4, 20, "t4_rd4");
    req = '0;
    wait_idle(20, "t4_idle");
    chk("t4_ngrants", 32'(g_val.size()), 32'(1));
    chk_grant("t4", 0, 1, 4);
    chk_rdgap("t4_pause", 2, 4);
    chk_rdgap("t4_resume", 3, 1);

    // Reset mid-burst, then pointer back at 0
    do_reset();
    push_words(20, 8'hA0);
    req = 4'b0101;
    wait_rd(2, 20, "t5_rd2");
    rst_n = 1'b0;
    #1;
    chk("t5_gnt", 32'(gnt), 32'(0));
    chk("t5_vld", 32'(vld), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_rd_en", 32'(rd_en), 32'(0));
    chk("t5_err", 32'(err), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clr_logs();
    wait_grants(1, 10, "t5_regrant");
    if (g_val.size() > 0)
      chk("t5_first", 32'(g_val[0]), 32'(1));
    req = '0;
    wait_idle(20, "t5_idle");

    // Error flag: ignored when idle, sticky once set in a grant
    do_reset();
    err_in = 1'b1;
    @(posedge clk);
    #2;
    err_in = 1'b0;
    @(negedge clk);
    chk("t6_err_idle", 32'(err), 32'(0));
    @(posedge clk);
    #2;
    clr_logs();
    push_words(20, 8'hC0);
    req = 4'b0010;
    wait_grants(1, 10, "t6_grant");
    err_in = 1'b1;
    @(negedge clk);
    chk("t6_err_pre", 32'(err), 32'(0));
    @(posedge clk);
    #2;
    err_in = 1'b0;
    @(negedge clk);
    chk("t6_err_set", 32'(err), 32'(1));
    wait_rd(12, 60, "t6_reads");
    chk("t6_err_sticky", 32'(err), 32'(1));
    req = '0;
    wait_idle(20, "t6_idle");
    do_reset();
    @(negedge clk);
    chk("t6_err_clr", 32'(err), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Round-robin read-port arbiter that shares the single read port of the asynchronous FIFO among NREQ consumers on the read clock domain. It grants one consumer at a time for a burst of up to BURST words and drives the FIFO read enable only when the FIFO is non-empty. It returns each read word tagged with a one-hot valid for the owning consumer. It sits between the FIFO read interface (rd_en/rdata/empty/error) and the downstream consumers.

## Interface
- WIDTH, 8, data width; equals FIFO data width
- NREQ, 4, number of consumers (2..8)
- BURST, 4, maximum reads per grant (1..16)
- TIMEOUT, 8, consecutive empty cycles tolerated while granted before release (1..255)

- rclk_i  in  1  read-domain clock; all logic on its rising edge
- rst_i  in  1  reset, asynchronous assert, active-low
- req_i  in  NREQ  per-consumer read request, level
- gnt_o  out  NREQ  one-hot grant, registered
- rd_en_o  out  1  FIFO read enable
- empty_i  in  1  FIFO empty flag
- rdata_i  in  WIDTH  FIFO read data; valid the cycle after rd_en_o
- error_i  in  1  FIFO read error/underflow flag
- vld_o  out  NREQ  one-hot data valid, registered
- rdata_o  out  WIDTH  data to consumers (rdata_i passed through)
- busy_o  out  1  high in GRANT state
- err_o  out  1  sticky error

## Operation
- States: IDLE, GRANT.
- Reset values: state=IDLE, gnt_o=0, vld_o=0, busy_o=0, err_o=0, rd_en_o=0, RR pointer=0, burst count=0, empty-timeout count=0.
- IDLE:
  - gnt_o=0 and rd_en_o=0.
  - If any req_i bit is set, select the first set bit searching from the RR pointer upward, wrapping at NREQ-1 -> 0.
  - Load gnt_o with that one-hot and go to GRANT.
  - Set RR pointer = winner+1 (mod NREQ).
  - Clear burst count and timeout count.
- GRANT, with g = granted index:
  - rd_en_o = req_i[g] & ~empty_i. This is combinational; rd_en_o is never high while empty_i=1.
  - Each rd_en_o cycle increments the burst count.
  - Each cycle with req_i[g]=1 and empty_i=1 increments the timeout count. Any cycle with rd_en_o=1 clears it.
  - Exit to IDLE (gnt_o cleared next edge) on any of:
    - the BURST-th rd_en_o issued;
    - req_i[g]=0;
    - timeout count reaches TIMEOUT.
  - Exit conditions are evaluated on the same edge as the read that completes the burst.
- Data return:
  - vld_o = registered (rd_en_o ? gnt_o : 0).
  - rdata_o = rdata_i.
  - The one-hot is captured at the rd_en_o edge, so the last word of a burst is still tagged correctly after gnt_o drops.
- err_o:
  - Set on error_i=1 sampled while busy_o=1, or on the cycle following rd_en_o.
  - Cleared only by reset.
- A consumer that keeps req_i high after its burst re-competes. Round-robin order guarantees every other pending requester is served first, so no starvation.
- busy_o = (state==GRANT).

## Timing
- req_i rises in IDLE at edge N -> gnt_o/busy_o high after edge N+1.
- First rd_en_o is possible in cycle N+1 (same cycle as grant, combinational).
- rd_en_o in cycle K -> vld_o/rdata_o valid in cycle K+1.
- Full burst with FIFO non-empty: BURST consecutive rd_en_o cycles, then one IDLE bubble cycle before the next grant. Minimum grant-to-grant spacing is BURST+1 cycles.
- Empty mid-burst: rd_en_o pauses and grant is held. Release happens on the edge where the timeout count reaches TIMEOUT.
- Request drop and FIFO non-empty in the same cycle: no read (rd_en_o=0), grant released.
- Reset asserted mid-burst:
  - Outputs clear immediately (asynchronous).
  - Any outstanding vld_o is lost.
  - Pointer restarts at 0.
- Simultaneous requests from all consumers at reset exit: grant order 0,1,2,3,0,...

## Test plan
- Single requester 1, FIFO holds 10 words, BURST=4:
  - gnt_o=0010 for 4 rd_en cycles, 1 bubble, then regrant.
  - vld_o=0010 on 10 words in order, each one cycle after its rd_en.
- req_i=1111 with FIFO always non-empty: grants cycle 0001->0010->0100->1000->0001, 4 words each, with exactly 1 IDLE cycle between grants.
- Grant to 0 with FIFO empty and req held: rd_en_o never asserts, grant releases after 8 cycles (TIMEOUT=8), busy_o falls.
- FIFO goes empty after word 2 of a burst and refills 3 cycles later: rd_en_o gaps 3 cycles, burst completes words 3-4 under the same grant.
- Reset asserted mid-burst (after 2 reads) with req_i=0101: all outputs 0 immediately. After release, first grant goes to consumer 0.
- error_i pulsed during a grant: err_o rises next edge and stays high through later bursts until reset.
